// File: rtl/gpio_in_debounce.sv
// GPIO input conditioner: 2-flop synchronizer, debounce FSM, edge pulses
// and a saturating rising-edge event counter.
module gpio_in_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_raw,
    input  logic             enable,
    input  logic             clr_cnt,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_ovf
);

    localparam int unsigned STAB_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_e;

    logic              s1_d, s1_q;
    logic              s2_d, s2_q;
    state_e            state_d, state_q;
    logic [STAB_W-1:0] stab_d, stab_q;
    logic              level_d, level_q;
    logic              rise_d, rise_q;
    logic              fall_d, fall_q;
    logic [CNT_W-1:0]  ecnt_d, ecnt_q;
    logic              ovf_d, ovf_q;

    // The synchronizer keeps running while disabled so re-enabling
    // sees a settled pad value.
    always_comb begin
        s1_d = in_raw;
        s2_d = s1_q;
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE_LO: begin
                if (enable && s2_q) begin
                    state_d = WAIT_HI;
                    stab_d  = '0;
                end
            end
            WAIT_HI: begin
                if (!enable || !s2_q) begin
                    state_d = IDLE_LO;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = IDLE_HI;
                    stab_d  = '0;
                    rise_d  = 1'b1;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            IDLE_HI: begin
                if (enable && !s2_q) begin
                    state_d = WAIT_LO;
                    stab_d  = '0;
                end
            end
            WAIT_LO: begin
                if (!enable || s2_q) begin
                    state_d = IDLE_HI;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = IDLE_LO;
                    stab_d  = '0;
                    fall_d  = 1'b1;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LO;
                stab_d  = '0;
            end
        endcase
        level_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    end

    // A clear wins over a coincident rise; that rise is dropped.
    always_comb begin
        ecnt_d = ecnt_q;
        ovf_d  = ovf_q;
        if (clr_cnt) begin
            ecnt_d = '0;
            ovf_d  = 1'b0;
        end else if (rise_d) begin
            if (ecnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                ecnt_d = ecnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE_LO;
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ecnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ecnt_q  <= ecnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign edge_cnt   = ecnt_q;
    assign cnt_ovf    = ovf_q;

endmodule
